pc_link_controller: RTL and testbench

- Sequences the PC cache/loader unit for control-flow operations: saving the 16-bit PC to memory as two bytes, and loading a 16-bit PC from memory as two bytes.
- Drives `cache_write` and `loader_select` on the cache/loader unit.
- Owns the shared byte-memory port while busy; the ALU/cache path must be idle while `busy` = 1.
- Supports SAVE, LOAD and CALL (SAVE then LOAD) as single accepted operations.

---
 rtl/pc_link_controller.sv | 123 ++++++++++++
 tb/tb_pc_link_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_link_controller.sv
// Sequencer for the PC cache/loader unit: saves the PC to memory as two bytes,
// loads it back as two bytes, or does both in order for a CALL.
module pc_link_controller #(
    parameter int ADDR_W = 16,
    parameter int STEP   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] save_addr,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic              cache_write,
    output logic              loader_select,
    output logic              pc_load,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_SAVE_HI,
        S_SAVE_LO,
        S_LOAD_HI,
        S_LOAD_LO,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_save_addr;
    logic [ADDR_W-1:0] r_load_addr;
    logic              r_is_call;
    logic              w_accept;

    assign w_accept = op_valid && (r_state == S_IDLE);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_save_addr <= '0;
            r_load_addr <= '0;
            r_is_call   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_save_addr <= save_addr;
                r_load_addr <= load_addr;
                r_is_call   <= (op_code == 2'b10);
            end
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        op_ready      = 1'b0;
        mem_addr      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        cache_write   = 1'b0;
        loader_select = 1'b0;
        pc_load       = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op_code)
                        2'b00, 2'b10: w_next = S_SNAP;
                        2'b01:        w_next = S_LOAD_HI;
                        default:      w_next = S_FIN;
                    endcase
                end
            end
            S_SNAP: begin
                cache_write = 1'b1;
                w_next      = S_SAVE_HI;
            end
            S_SAVE_HI: begin
                mem_write = 1'b1;
                mem_addr  = r_save_addr;
                if (mem_ack) w_next = S_SAVE_LO;
            end
            S_SAVE_LO: begin
                mem_write     = 1'b1;
                loader_select = 1'b1;
                mem_addr      = r_save_addr + STEP_V;
                if (mem_ack) w_next = r_is_call ? S_LOAD_HI : S_FIN;
            end
            S_LOAD_HI: begin
                mem_read      = 1'b1;
                loader_select = 1'b1;
                mem_addr      = r_load_addr;
                if (mem_ack) w_next = S_LOAD_LO;
            end
            S_LOAD_LO: begin
                // The only output that depends on an input: the PC takes {upper, mem_out} in the ack cycle.
                mem_read = 1'b1;
                mem_addr = r_load_addr + STEP_V;
                pc_load  = mem_ack;
                if (mem_ack) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pc_link_controller.sv
// Bench for pc_link_controller: models the PC cache/loader unit and a byte memory with
// random wait states, and checks each operation against a transaction-level reference.
module tb_pc_link_controller;

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] save_addr;
    logic [15:0] load_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        cache_write;
    logic        loader_select;
    logic        pc_load;
    logic        busy;
    logic        done;

    pc_link_controller #(.ADDR_W(16), .STEP(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .save_addr    (save_addr),
        .load_addr    (load_addr),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .cache_write  (cache_write),
        .loader_select(loader_select),
        .pc_load      (pc_load),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: cache/loader unit and byte memory ----------------
    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [7:0]  cached_lower;
    logic [7:0]  upper;
    logic [7:0]  mem_out = 8'h00;
    logic [7:0]  save_out;
    logic        pc_set = 1'b0;
    logic [15:0] pc_set_val = 16'h0000;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0000;
    logic [7:0]  poke_data = 8'h00;

    assign save_out = loader_select ? cached_lower : pc[15:8];

    always @(posedge clock) begin
        if (pc_set)       pc <= pc_set_val;
        else if (pc_load) pc <= {upper, mem_out};
        if (cache_write) cached_lower <= pc[7:0];
        if (loader_select && mem_read && mem_ack) upper <= mem_out;
        if (poke_en)                    mem[poke_addr] <= poke_data;
        else if (mem_write && mem_ack)  mem[mem_addr]  <= save_out;
    end

    // Memory responder: per-access wait counts come from dly[], in access order.
    int dly [4];
    int acc_idx   = 0;
    int wait_left = 0;
    bit in_req    = 1'b0;

    always @(posedge clock) begin
        #1;
        if (reset || !busy) acc_idx = 0;
        if (reset || !(mem_read || mem_write)) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
        end else begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = (acc_idx < 4) ? dly[acc_idx] : 0;
            end
            if (wait_left == 0) begin
                mem_ack = 1'b1;
                in_req  = 1'b0;
                mem_out = mem[mem_addr];
                acc_idx++;
            end else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end
    end

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic [7:0]  ref_mem [0:65535];
    acc_t        exp_acc [4];
    int          exp_n   = 0;
    int          exp_lat = 0;
    int          exp_cw  = 0;
    int          exp_pl  = 0;
    logic [15:0] exp_pc  = 16'h0000;
    logic [15:0] model_pc = 16'h0000;

    task automatic add_access(input logic wr, input logic [15:0] a, input logic [7:0] d);
        exp_acc[exp_n] = {wr, a, d};
        exp_lat += dly[exp_n] + 1;
        exp_n++;
    endtask

    // Expected accesses, latency and final PC of one op, from the op's definition.
    task automatic plan_op(input logic [1:0] op, input logic [15:0] s, input logic [15:0] l);
        logic [15:0] a1;
        exp_n = 0; exp_lat = 1; exp_cw = 0; exp_pl = 0;
        if (op == 2'b00 || op == 2'b10) begin
            exp_lat += 1;
            exp_cw = 1;
            a1 = s + 16'd1;
            add_access(1'b1, s, model_pc[15:8]);
            ref_mem[s] = model_pc[15:8];
            add_access(1'b1, a1, model_pc[7:0]);
            ref_mem[a1] = model_pc[7:0];
        end
        if (op == 2'b01 || op == 2'b10) begin
            a1 = l + 16'd1;
            add_access(1'b0, l, 8'h00);
            add_access(1'b0, a1, 8'h00);
            model_pc = {ref_mem[l], ref_mem[a1]};
            exp_pl = 1;
        end
        exp_pc = model_pc;
    endtask

    // ---------------- compare process ----------------
    int lat = 0, idx = 0, cw_cnt = 0, pl_cnt = 0, last_lat = 0;

    always @(negedge clock) begin
        if (reset) begin
            lat = 0; idx = 0; cw_cnt = 0; pl_cnt = 0;
        end else begin
            check("rd_wr_exclusive", 32'(mem_read & mem_write), 0);
            check("ready_vs_busy", 32'(op_ready), 32'(!busy));
            if (!busy) begin
                check("idle_outputs",
                      {10'd0, mem_addr, mem_read, mem_write, cache_write, loader_select, pc_load, done}, 0);
                lat = 0; idx = 0; cw_cnt = 0; pl_cnt = 0;
            end else begin
                lat++;
                if (cache_write) cw_cnt++;
                if (pc_load) begin
                    pl_cnt++;
                    check("pc_load_on_read_ack", 32'(mem_read & mem_ack), 1);
                end
                if ((mem_read || mem_write) && mem_ack) begin
                    if (idx >= exp_n) begin
                        check("extra_access", 1, 0);
                    end else begin
                        check("access_kind", 32'(mem_write), 32'(exp_acc[idx].wr));
                        check("access_addr", 32'(mem_addr), 32'(exp_acc[idx].addr));
                        if (exp_acc[idx].wr) check("write_data", 32'(save_out), 32'(exp_acc[idx].data));
                    end
                    idx++;
                end
                if (done) begin
                    check("latency", lat, exp_lat);
                    check("access_count", idx, exp_n);
                    check("cache_write_count", cw_cnt, exp_cw);
                    check("pc_load_count", pl_cnt, exp_pl);
                    check("pc_after_op", 32'(pc), 32'(exp_pc));
                    last_lat = lat;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_pc(input logic [15:0] v);
        pc_set = 1'b1; pc_set_val = v;
        @(posedge clock); @(negedge clock);
        pc_set = 1'b0;
        model_pc = v;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        ref_mem[a] = d;
        @(posedge clock); @(negedge clock);
        poke_en = 1'b0;
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] s, input logic [15:0] l, input bit hold);
        int guard;
        plan_op(op, s, l);
        check("ready_before_op", 32'(op_ready), 1);
        op_valid = 1'b1; op_code = op; save_addr = s; load_addr = l;
        @(posedge clock); @(negedge clock);
        guard = 0;
        while (!done && guard < 200) begin
            if (hold) op_code = 2'($urandom);
            else      op_valid = 1'b0;
            save_addr = 16'($urandom);
            load_addr = 16'($urandom);
            @(negedge clock);
            guard++;
        end
        op_valid = 1'b0;
        if (!done) begin
            check("done_timeout", 0, 1);
            #1 reset = 1'b1;
            @(negedge clock);
            #1 reset = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int guard;
        reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; save_addr = 16'h0; load_addr = 16'h0;
        set_dly(0, 0, 0, 0);
        #2;
        check("reset_outputs",
              {10'd0, mem_addr, mem_read, mem_write, cache_write, loader_select, pc_load, done}, 0);
        check("reset_ready", 32'(op_ready), 1);
        check("reset_busy", 32'(busy), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // SAVE, zero-wait
        set_pc(16'hBEEF);
        set_dly(0, 0, 0, 0);
        run_op(2'b00, 16'h0100, 16'h0000, 1'b0);
        check("save_latency", last_lat, 4);
        check("save_hi_byte", 32'(mem[16'h0100]), 32'h BE);
        check("save_lo_byte", 32'(mem[16'h0101]), 32'h EF);
        check("save_pc_kept", 32'(pc), 32'h BEEF);

        // LOAD with two wait cycles per access, op_valid held while busy
        poke(16'h0200, 8'h12);
        poke(16'h0201, 8'h34);
        set_dly(2, 2, 0, 0);
        run_op(2'b01, 16'h0000, 16'h0200, 1'b1);
        check("load_latency", last_lat, 7);
        check("load_pc", 32'(pc), 32'h1234);

        // CALL, zero-wait
        set_pc(16'h00A5);
        poke(16'h0300, 8'h40);
        poke(16'h0301, 8'h00);
        set_dly(0, 0, 0, 0);
        run_op(2'b10, 16'h0010, 16'h0300, 1'b0);
        check("call_latency", last_lat, 6);
        check("call_hi_byte", 32'(mem[16'h0010]), 32'h00);
        check("call_lo_byte", 32'(mem[16'h0011]), 32'h A5);
        check("call_pc", 32'(pc), 32'h4000);

        // Address wrap-around
        set_pc(16'h5A5A);
        run_op(2'b00, 16'hFFFF, 16'h0000, 1'b0);
        check("wrap_hi_byte", 32'(mem[16'hFFFF]), 32'h5A);
        check("wrap_lo_byte", 32'(mem[16'h0000]), 32'h5A);

        // Reserved op
        run_op(2'b11, 16'h1111, 16'h2222, 1'b0);
        check("reserved_latency", last_lat, 1);

        // Reset while in SAVE_LO
        set_pc(16'h1234);
        set_dly(0, 6, 0, 0);
        plan_op(2'b00, 16'h0400, 16'h0000);
        op_valid = 1'b1; op_code = 2'b00; save_addr = 16'h0400; load_addr = 16'h0000;
        @(posedge clock); @(negedge clock);
        op_valid = 1'b0;
        guard = 0;
        while (!(mem_write && mem_addr == 16'h0401) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("reached_save_lo", 32'(mem_write && mem_addr == 16'h0401), 1);
        #1 reset = 1'b1;
        #1;
        check("abort_outputs",
              {10'd0, mem_addr, mem_read, mem_write, cache_write, loader_select, pc_load, done}, 0);
        check("abort_ready", 32'(op_ready), 1);
        @(negedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no_done_after_abort", 32'(done | pc_load), 0);
        end
        check("abort_pc_kept", 32'(pc), 32'h1234);
        check("abort_ready_after", 32'(op_ready), 1);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  op;
            logic [15:0] s;
            logic [15:0] l;
            op = 2'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       l = s;
                1:       l = s + 16'd1;
                default: l = 16'($urandom);
            endcase
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            set_pc(16'($urandom));
            poke(l, 8'($urandom));
            poke(l + 16'd1, 8'($urandom));
            run_op(op, s, l, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
